umq_access_arbiter: RTL
=======================

Name: umq_access_arbiter

Overview:
- Front-end controller for the unexpected-message-queue CAM.
- Sits between the network packetizer (insert side) and the receive-request engine (find side). Grants exactly one operation at a time to the CAM, round-robin.
- Issues single-cycle insert/find strobes, waits for the CAM's found/not_found pulse and returns the result to the requester through a valid/ready response channel.
- Tracks queue occupancy, applies backpressure on the network side, and keeps saturating hit/miss/insert statistics.

Parameters:
- packetizer_width, 128, width of the network message bus.
- ADDR_WIDTH, 16, CAM address width; the find key is request[ADDR_WIDTH-1:0].
- DEPTH_LIMIT, 65535, occupancy at which net_ready is held low.
- FIND_TIMEOUT, 15, cycles to wait for found/not_found before a forced miss.
- STAT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- net_valid  in  1  network message available
- net_ready  out  1  arbiter accepts the message this cycle
- net_message  in  packetizer_width  header+payload; key = [103:88]
- req_valid  in  1  receive request available
- req_ready  out  1  arbiter accepts the request this cycle
- req_request  in  32  request word; [15:0] = key
- resp_valid  out  1  find result valid
- resp_ready  in  1  consumer takes the result
- resp_found  out  1  1 = hit, 0 = miss
- resp_timeout  out  1  miss was forced by timeout
- resp_data  out  32  matched payload (0 on miss)
- cam_insert  out  1  insert strobe to the CAM
- cam_message  out  packetizer_width  registered message to the CAM
- cam_find  out  1  find strobe to the CAM
- cam_request  out  32  registered request to the CAM
- cam_found  in  1  CAM hit pulse
- cam_not_found  in  1  CAM miss pulse
- cam_data  in  32  CAM unexpected_message
- occupancy  out  ADDR_WIDTH+1  current entries
- stat_ins, stat_hit, stat_miss  out  STAT_WIDTH each  saturating counters

Behaviour:
- Reset: all outputs are 0; FSM is in IDLE; last_grant = FIND, so the network wins the first tie.
- A handshake is accepted when valid && ready. net_ready and req_ready are combinational and are high only in IDLE.
  - net_ready also requires occupancy < DEPTH_LIMIT.
  - Never both high in the same cycle: on a tie only the round-robin winner's ready is high.
- Arbitration in IDLE:
  - Only one side valid (and eligible): that side is granted.
  - Both valid: grant the side opposite last_grant.
  - A network message while full is not eligible, so the request is granted even on a tie.
- FSM states:
  - IDLE. On an insert grant: latch message, cam_insert = 1 for one cycle, occupancy++ and stat_ins++, go to GUARD. On a find grant: latch request, cam_find = 1 for one cycle, clear the timer, go to FIND_WAIT.
  - FIND_WAIT. The timer increments each cycle.
    - cam_found: latch cam_data, found = 1, occupancy--, stat_hit++, go to RESP.
    - cam_not_found: data = 0, found = 0, stat_miss++, go to RESP.
    - Timer reaches FIND_TIMEOUT: found = 0, timeout = 1, stat_miss++, go to RESP.
  - RESP. resp_valid = 1 and the outputs stay stable until resp_ready. On the handshake go to GUARD.
  - GUARD. One idle cycle so the CAM's internal FSM and counters settle, then IDLE.
- Throughput:
  - Insert: one per 2 cycles.
  - Find: at least 4 cycles (accept, CAM read, response, guard). The CAM answers 1 cycle after a miss strobe and 2 after a hit strobe.
- Occupancy never wraps: decrement only on cam_found, increment only on accepted inserts. Both are serialized, so they are never simultaneous.
- cam_found or cam_not_found outside FIND_WAIT is ignored. A late response after a timeout is also dropped.
- Statistics counters saturate at all-ones and do not wrap.
- rst asserted in any state (including mid-RESP) returns immediately to reset values. The pending response is lost.

Test Plan:
- Insert key 0x0005, payload 0xDEADBEEF, then find 0x0005. Expect cam_insert pulse 1 cycle, occupancy 1; then resp_found = 1, resp_data = 0xDEADBEEF, occupancy 0, stat_ins = stat_hit = 1.
- Find 0x0007 on an empty CAM (cam_not_found the next cycle). Expect resp_found = 0, resp_data = 0, resp_timeout = 0, stat_miss = 1.
- net_valid and req_valid held high together for 4 grants. Expect grants N, F, N, F, with exactly one ready high per accepted cycle.
- Find with the CAM model mute. Expect resp_valid after FIND_TIMEOUT + 1 cycles with resp_timeout = 1; a later spurious cam_found leaves occupancy unchanged.
- DEPTH_LIMIT = 2, three inserts offered. Expect net_ready low after the second; a simultaneous request is granted; after the hit, net_ready rises again.
- resp_ready held low for 5 cycles, then rst pulsed. Expect resp_data stable while low, then all outputs 0 and the FSM in IDLE on the cycle after rst.

Source files
------------

// File: rtl/umq_access_arbiter.sv
// Front-end arbiter for the unexpected-message-queue CAM: serializes network inserts
// and receive-request finds round-robin, and returns find results over valid/ready.
module umq_access_arbiter #(
  parameter int packetizer_width = 128,
  parameter int ADDR_WIDTH       = 16,
  parameter int DEPTH_LIMIT      = 65535,
  parameter int FIND_TIMEOUT     = 15,
  parameter int STAT_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        net_valid,
  output logic                        net_ready,
  input  logic [packetizer_width-1:0] net_message,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [31:0]                 req_request,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic                        resp_found,
  output logic                        resp_timeout,
  output logic [31:0]                 resp_data,
  output logic                        cam_insert,
  output logic [packetizer_width-1:0] cam_message,
  output logic                        cam_find,
  output logic [31:0]                 cam_request,
  input  logic                        cam_found,
  input  logic                        cam_not_found,
  input  logic [31:0]                 cam_data,
  output logic [ADDR_WIDTH:0]         occupancy,
  output logic [STAT_WIDTH-1:0]       stat_ins,
  output logic [STAT_WIDTH-1:0]       stat_hit,
  output logic [STAT_WIDTH-1:0]       stat_miss
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_FIND_WAIT = 2'd1;
  localparam logic [1:0] S_RESP      = 2'd2;
  localparam logic [1:0] S_GUARD     = 2'd3;

  localparam logic GRANT_NET  = 1'b0;
  localparam logic GRANT_FIND = 1'b1;

  localparam int TIMER_W = $clog2(FIND_TIMEOUT + 2);
  localparam logic [TIMER_W-1:0]  TIMEOUT_V   = TIMER_W'(FIND_TIMEOUT);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM_V = (ADDR_WIDTH + 1)'(DEPTH_LIMIT);

  logic [1:0]                  state_q, state_d;
  logic                        last_grant_q, last_grant_d;
  logic [packetizer_width-1:0] msg_q, msg_d;
  logic [31:0]                 req_q, req_d;
  logic                        cam_insert_q, cam_insert_d;
  logic                        cam_find_q, cam_find_d;
  logic [TIMER_W-1:0]          timer_q, timer_d;
  logic                        found_q, found_d;
  logic                        timeout_q, timeout_d;
  logic [31:0]                 data_q, data_d;
  logic [ADDR_WIDTH:0]         occ_q, occ_d;
  logic [STAT_WIDTH-1:0]       ins_q, ins_d;
  logic [STAT_WIDTH-1:0]       hit_q, hit_d;
  logic [STAT_WIDTH-1:0]       miss_q, miss_d;

  logic idle;
  logic net_eligible;
  logic grant_net;
  logic grant_req;

  // A full queue makes the network side ineligible, so a pending request wins any tie.
  assign idle         = (state_q == S_IDLE);
  assign net_eligible = net_valid && (occ_q < DEPTH_LIM_V);
  assign grant_net    = idle && net_eligible && (!req_valid || last_grant_q == GRANT_FIND);
  assign grant_req    = idle && req_valid && (!net_eligible || last_grant_q == GRANT_NET);

  assign net_ready    = grant_net;
  assign req_ready    = grant_req;
  assign resp_valid   = (state_q == S_RESP);
  assign resp_found   = found_q;
  assign resp_timeout = timeout_q;
  assign resp_data    = data_q;
  assign cam_insert   = cam_insert_q;
  assign cam_message  = msg_q;
  assign cam_find     = cam_find_q;
  assign cam_request  = req_q;
  assign occupancy    = occ_q;
  assign stat_ins     = ins_q;
  assign stat_hit     = hit_q;
  assign stat_miss    = miss_q;

  always_comb begin
    // NOTE: every _d starts from its held value so no path through the case leaves a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    msg_d        = msg_q;
    req_d        = req_q;
    cam_insert_d = 1'b0;
    cam_find_d   = 1'b0;
    timer_d      = timer_q;
    found_d      = found_q;
    timeout_d    = timeout_q;
    data_d       = data_q;
    occ_d        = occ_q;
    ins_d        = ins_q;
    hit_d        = hit_q;
    miss_d       = miss_q;

    case (state_q)
      S_IDLE: begin
        if (grant_net) begin
          msg_d        = net_message;
          cam_insert_d = 1'b1;
          occ_d        = occ_q + 1'b1;
          if (ins_q != '1) ins_d = ins_q + 1'b1;
          last_grant_d = GRANT_NET;
          state_d      = S_GUARD;
        end else if (grant_req) begin
          req_d        = req_request;
          cam_find_d   = 1'b1;
          timer_d      = '0;
          last_grant_d = GRANT_FIND;
          state_d      = S_FIND_WAIT;
        end
      end
      S_FIND_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (cam_found) begin
          data_d    = cam_data;
          found_d   = 1'b1;
          timeout_d = 1'b0;
          if (occ_q != '0) occ_d = occ_q - 1'b1;
          if (hit_q != '1) hit_d = hit_q + 1'b1;
          state_d   = S_RESP;
        end else if (cam_not_found || timer_q == TIMEOUT_V) begin
          data_d    = '0;
          found_d   = 1'b0;
          timeout_d = !cam_not_found;
          if (miss_q != '1) miss_d = miss_q + 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_GUARD;
      end
      S_GUARD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_FIND;
      // NOTE: the wide message/request registers are reset too, because they drive ports that must read 0 out of reset.
      msg_q        <= '0;
      req_q        <= '0;
      cam_insert_q <= 1'b0;
      cam_find_q   <= 1'b0;
      timer_q      <= '0;
      found_q      <= 1'b0;
      timeout_q    <= 1'b0;
      data_q       <= '0;
      occ_q        <= '0;
      ins_q        <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values computed above.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      msg_q        <= msg_d;
      req_q        <= req_d;
      cam_insert_q <= cam_insert_d;
      cam_find_q   <= cam_find_d;
      timer_q      <= timer_d;
      found_q      <= found_d;
      timeout_q    <= timeout_d;
      data_q       <= data_d;
      occ_q        <= occ_d;
      ins_q        <= ins_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

endmodule
